repne_cmps_sequencer: RTL and testbench
=======================================

# repne_cmps_sequencer

Sequencer for CMPS and REPNE CMPS string instructions in the writeback stage. It stalls decode and issues the two CMPS micro-op phases (`first_uop`, `second_uop`) once per iteration. It also tracks the ESI/EDI pointers and the ECX count across iterations, and evaluates REPNE termination from the compare's ZF. Its outputs drive the CMPS-phase and REPNE-first control inputs of writeback and the GPR2/GPR3 write-enables.

## Interface

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: decode presents a CMPS instruction; sampled only in IDLE.
- `rep` in 1: REPNE prefix present; sampled with `start`.
- `datasize` in 2: element size. 0 = byte, 1 = word, 2 = dword, 3 = treated as dword.
- `df` in 1: direction flag. 0 = increment, 1 = decrement; sampled with `start`.
- `esi_in`, `edi_in`, `ecx_in` in 32 each: architectural values; sampled with `start`.
- `uop_ack` in 1: writeback retired the current first-phase uop (already qualified by WB_V).
- `cmp_done` in 1: writeback retired the compare uop (already qualified by WB_V).
- `zf_in` in 1: ZF of that compare; valid only with `cmp_done`.
- `busy` out 1: high in every state except IDLE; drives the decode stall.
- `first_uop` out 1: CMPS first-phase indicator.
- `second_uop` out 1: CMPS second-phase indicator.
- `first_of_repne` out 1: high during the first UOP1 of a `rep` sequence only.
- `esi_out`, `edi_out`, `ecx_out` out 32 each: internal pointer and count registers.
- `ld_ptrs` out 1: one-cycle pulse; writeback loads ESI/EDI from `esi_out`/`edi_out`.
- `ld_ecx` out 1: one-cycle pulse; writeback loads ECX from `ecx_out` (rep only).
- `done` out 1: one-cycle pulse at sequence end.
- `repne_term` out 1: high with `done` when a rep sequence ended; stays 0 for non-rep sequences.

## Operation

States: IDLE, UOP1, UOP2, DONE (2-bit encoded, registered).

- **IDLE**
  - On `start`, latch `rep`, `df`, size, `esi_in`, `edi_in` and `ecx_in`.
  - If `rep` and `ecx_in == 0`: go to DONE; no uops are issued.
  - Otherwise go to UOP1 and set the internal `first_iter` flag.
- **UOP1**
  - Assert `first_uop`; `first_of_repne = rep & first_iter`.
  - On `uop_ack`: clear `first_iter` and go to UOP2.
- **UOP2**
  - Assert `second_uop`.
  - On `cmp_done`, update registers:
    - ESI and EDI each change by ±size, where size is 1, 2 or 4 and the sign is set by df.
    - If rep, ECX decrements by 1.
  - Also on `cmp_done`, pulse `ld_ptrs` and (if rep) `ld_ecx` in the next cycle.
  - Next state:
    - Non-rep: go to DONE.
    - Rep: go to DONE if `zf_in` is 1 or the decremented ECX is 0 (latch `term = 1`); otherwise go to UOP1.
- **DONE**
  - Pulse `done`; `repne_term = rep & term`; return to IDLE.

Arithmetic and boundary rules:
- Pointer arithmetic is modulo 2^32; wrap-around is silent.
- ECX never decrements below 0, because a sequence entered with ECX = 0 is bypassed.
- `start` is ignored in any state other than IDLE.
- `uop_ack` outside UOP1 and `cmp_done` outside UOP2 are ignored.
- If `uop_ack` and `cmp_done` arrive together in UOP1, only `uop_ack` is honored.
- `first_uop` and `second_uop` are never high together.

## Timing

- **Reset:** state = IDLE; all output registers, `first_iter` and `term` = 0; every output reads 0 in the cycle after `RST` is sampled.
- **Reset mid-operation:** the sequence is abandoned; no `done` or `ld_*` pulse is produced.
- **Latency:**
  - `start` at edge N: UOP1 (or DONE for the ECX = 0 bypass) is visible at N+1.
  - `cmp_done` at edge M: updated `*_out` values and the `ld_*` pulses are visible at M+1, together with the next state.
- **Minimum per-iteration cost:** 2 cycles (`uop_ack` arrives immediately in UOP1 and `cmp_done` immediately in UOP2).
- **Output decoding:** all outputs are decoded from registered state or registered flags, with no combinational path from inputs to outputs.

## Test plan

- **Non-rep CMPSB:** df = 0, esi = 0x1000, edi = 0x2000, ecx = 7; immediate acks.
  - Expect esi_out = 0x1001, edi_out = 0x2001, ecx_out = 7.
  - Expect `ld_ecx` never pulses, `done` = 1, `repne_term` = 0, and `busy` high for exactly 3 cycles.
- **REPNE CMPSD, no match:** ecx = 3, df = 0, zf always 0.
  - Expect 3 iterations and `first_of_repne` high in exactly one cycle.
  - Final state: esi_out = 0x100C, ecx_out = 0, `repne_term` = 1.
- **REPNE CMPSW, match on second compare:** ecx = 5, df = 1, esi = 0x1000, zf = 1 on the second compare.
  - Final state: esi_out = 0x0FFC, ecx_out = 3, `repne_term` = 1.
- **REPNE with ecx = 0:**
  - Expect no `first_uop` or `second_uop`, `done` at start+1, `repne_term` = 1, and no `ld_*` pulses.
- **Wrap-around:** dword, df = 0, esi = 0xFFFFFFFE.
  - Expect esi_out = 0x00000002.
  - Repeat with df = 1, byte, edi = 0: expect edi_out = 0xFFFFFFFF.
- **Reset and ignored inputs:**
  - Assert `RST` while in UOP2: next cycle is IDLE with all outputs 0.
  - `start` pulsed while busy is ignored.
  - `cmp_done` pulsed in UOP1 causes no register change.

Source files
------------

// File: rtl/repne_cmps_sequencer.sv
// repne_cmps_sequencer
// Writeback-stage sequencer for CMPS / REPNE CMPS. Stalls decode while a
// string compare is in flight, issues the two CMPS micro-op phases once per
// iteration, keeps private copies of ESI/EDI/ECX, and decides REPNE
// termination from the compare's ZF.
//
// Handshake: uop_ack and cmp_done are single-cycle, already-qualified
// retirement strobes from writeback. uop_ack is honored only while UOP1 is
// showing, and cmp_done only while UOP2 is showing; anywhere else they are
// dropped. There is no backpressure on the outputs: ld_ptrs, ld_ecx and done
// are one-cycle pulses that writeback must consume in the cycle they appear.
//
// All outputs come straight from flops. Their next values are derived from
// the next-state values, so each output changes on the same edge as the
// state that it describes, and no input reaches an output combinationally.
// dbg_state_o exposes the FSM state for checkers.

module repne_cmps_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        rep,
  input  logic [1:0]  datasize,
  input  logic        df,
  input  logic [31:0] esi_in,
  input  logic [31:0] edi_in,
  input  logic [31:0] ecx_in,
  input  logic        uop_ack,
  input  logic        cmp_done,
  input  logic        zf_in,
  output logic        busy,
  output logic        first_uop,
  output logic        second_uop,
  output logic        first_of_repne,
  output logic [31:0] esi_out,
  output logic [31:0] edi_out,
  output logic [31:0] ecx_out,
  output logic        ld_ptrs,
  output logic        ld_ecx,
  output logic        done,
  output logic        repne_term,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UOP1 = 2'd1,
    S_UOP2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sequence state
  state_t      state_q, state_d;
  logic        rep_q, rep_d;
  logic        df_q, df_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] esi_q, esi_d;
  logic [31:0] edi_q, edi_d;
  logic [31:0] ecx_q, ecx_d;
  logic        first_iter_q, first_iter_d;
  logic        term_q, term_d;

  // Registered outputs
  logic        ld_ptrs_q, ld_ptrs_d;
  logic        ld_ecx_q, ld_ecx_d;
  logic        busy_q, busy_d;
  logic        first_uop_q, first_uop_d;
  logic        second_uop_q, second_uop_d;
  logic        first_of_repne_q, first_of_repne_d;
  logic        done_q, done_d;
  logic        repne_term_q, repne_term_d;

  // Datapath helpers
  logic [31:0] step;
  logic [31:0] ecx_dec;

  // Element size in bytes; encoding 3 behaves as a dword.
  function automatic logic [2:0] size_bytes(input logic [1:0] ds);
    logic [2:0] sz;
    case (ds)
      2'd0:    sz = 3'd1;
      2'd1:    sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d      = state_q;
    rep_d        = rep_q;
    df_d         = df_q;
    size_d       = size_q;
    esi_d        = esi_q;
    edi_d        = edi_q;
    ecx_d        = ecx_q;
    first_iter_d = first_iter_q;
    term_d       = term_q;
    ld_ptrs_d    = 1'b0;
    ld_ecx_d     = 1'b0;
    step         = {29'd0, size_q};
    ecx_dec      = ecx_q - 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rep_d  = rep;
          df_d   = df;
          size_d = size_bytes(datasize);
          esi_d  = esi_in;
          edi_d  = edi_in;
          ecx_d  = ecx_in;
          // A REPNE with nothing to count is finished before it starts;
          // it still reports termination so writeback sees a clean end.
          if (rep && (ecx_in == 32'd0)) begin
            state_d      = S_DONE;
            term_d       = 1'b1;
            first_iter_d = 1'b0;
          end else begin
            state_d      = S_UOP1;
            term_d       = 1'b0;
            first_iter_d = 1'b1;
          end
        end
      end

      S_UOP1: begin
        // A cmp_done arriving here (even alongside uop_ack) is dropped.
        if (uop_ack) begin
          first_iter_d = 1'b0;
          state_d      = S_UOP2;
        end
      end

      S_UOP2: begin
        if (cmp_done) begin
          // Pointer arithmetic wraps silently at 2^32.
          esi_d     = df_q ? (esi_q - step) : (esi_q + step);
          edi_d     = df_q ? (edi_q - step) : (edi_q + step);
          ld_ptrs_d = 1'b1;
          if (rep_q) begin
            ecx_d    = ecx_dec;
            ld_ecx_d = 1'b1;
            if (zf_in || (ecx_dec == 32'd0)) begin
              term_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_UOP1;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d           = (state_d != S_IDLE);
    first_uop_d      = (state_d == S_UOP1);
    second_uop_d     = (state_d == S_UOP2);
    first_of_repne_d = (state_d == S_UOP1) & rep_d & first_iter_d;
    done_d           = (state_d == S_DONE);
    repne_term_d     = (state_d == S_DONE) & rep_d & term_d;
  end

  // State, datapath and output registers; reset abandons any sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= S_IDLE;
      rep_q            <= 1'b0;
      df_q             <= 1'b0;
      size_q           <= 3'd0;
      esi_q            <= 32'd0;
      edi_q            <= 32'd0;
      ecx_q            <= 32'd0;
      first_iter_q     <= 1'b0;
      term_q           <= 1'b0;
      ld_ptrs_q        <= 1'b0;
      ld_ecx_q         <= 1'b0;
      busy_q           <= 1'b0;
      first_uop_q      <= 1'b0;
      second_uop_q     <= 1'b0;
      first_of_repne_q <= 1'b0;
      done_q           <= 1'b0;
      repne_term_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      rep_q            <= rep_d;
      df_q             <= df_d;
      size_q           <= size_d;
      esi_q            <= esi_d;
      edi_q            <= edi_d;
      ecx_q            <= ecx_d;
      first_iter_q     <= first_iter_d;
      term_q           <= term_d;
      ld_ptrs_q        <= ld_ptrs_d;
      ld_ecx_q         <= ld_ecx_d;
      busy_q           <= busy_d;
      first_uop_q      <= first_uop_d;
      second_uop_q     <= second_uop_d;
      first_of_repne_q <= first_of_repne_d;
      done_q           <= done_d;
      repne_term_q     <= repne_term_d;
    end
  end

  assign busy           = busy_q;
  assign first_uop      = first_uop_q;
  assign second_uop     = second_uop_q;
  assign first_of_repne = first_of_repne_q;
  assign esi_out        = esi_q;
  assign edi_out        = edi_q;
  assign ecx_out        = ecx_q;
  assign ld_ptrs        = ld_ptrs_q;
  assign ld_ecx         = ld_ecx_q;
  assign done           = done_q;
  assign repne_term     = repne_term_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_repne_cmps_sequencer.sv
// Testbench for repne_cmps_sequencer: directed sequences with hand-computed
// results pushed into an expected queue; a negedge monitor pops one entry
// per done pulse and compares final registers and per-sequence pulse counts.

module tb_repne_cmps_sequencer;

  // Clock / reset
  logic        CLK;
  logic        RST;
  logic        start, rep, df, uop_ack, cmp_done, zf_in;
  logic [1:0]  datasize;
  logic [31:0] esi_in, edi_in, ecx_in;
  logic        busy, first_uop, second_uop, first_of_repne;
  logic [31:0] esi_out, edi_out, ecx_out;
  logic        ld_ptrs, ld_ecx, done, repne_term;
  logic [1:0]  dbg_state_o;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  repne_cmps_sequencer dut (
    .CLK            (CLK),
    .RST            (RST),
    .start          (start),
    .rep            (rep),
    .datasize       (datasize),
    .df             (df),
    .esi_in         (esi_in),
    .edi_in         (edi_in),
    .ecx_in         (ecx_in),
    .uop_ack        (uop_ack),
    .cmp_done       (cmp_done),
    .zf_in          (zf_in),
    .busy           (busy),
    .first_uop      (first_uop),
    .second_uop     (second_uop),
    .first_of_repne (first_of_repne),
    .esi_out        (esi_out),
    .edi_out        (edi_out),
    .ecx_out        (ecx_out),
    .ld_ptrs        (ld_ptrs),
    .ld_ecx         (ld_ecx),
    .done           (done),
    .repne_term     (repne_term),
    .dbg_state_o    (dbg_state_o)
  );

  // Scoreboard
  typedef struct packed {
    logic [31:0] esi;
    logic [31:0] edi;
    logic [31:0] ecx;
    logic        term;
    logic [7:0]  busy_cyc;
    logic [7:0]  for_cyc;
    logic [7:0]  ldecx;
    logic [7:0]  ldp;
    logic [7:0]  u1;
    logic [7:0]  u2;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] e_esi, input logic [31:0] e_edi,
                              input logic [31:0] e_ecx, input logic e_term,
                              input int bc, input int fc, input int lec,
                              input int lp, input int u1, input int u2);
    exp_t e;
    e.esi      = e_esi;
    e.edi      = e_edi;
    e.ecx      = e_ecx;
    e.term     = e_term;
    e.busy_cyc = 8'(bc);
    e.for_cyc  = 8'(fc);
    e.ldecx    = 8'(lec);
    e.ldp      = 8'(lp);
    e.u1       = 8'(u1);
    e.u2       = 8'(u2);
    return e;
  endfunction

  // Monitor: per-sequence pulse counters, popped and compared on done.
  int c_busy, c_for, c_ldecx, c_ldp, c_u1, c_u2;

  always @(negedge CLK) begin
    exp_t e;
    if (first_uop || second_uop)
      chk("uop_exclusive", {31'd0, first_uop & second_uop}, 32'd0);
    if (!busy) begin
      c_busy = 0; c_for = 0; c_ldecx = 0; c_ldp = 0; c_u1 = 0; c_u2 = 0;
    end else begin
      c_busy  = c_busy + 1;
      c_for   = c_for + int'(first_of_repne);
      c_ldecx = c_ldecx + int'(ld_ecx);
      c_ldp   = c_ldp + int'(ld_ptrs);
      c_u1    = c_u1 + int'(first_uop);
      c_u2    = c_u2 + int'(second_uop);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("esi_out",        esi_out, e.esi);
          chk("edi_out",        edi_out, e.edi);
          chk("ecx_out",        ecx_out, e.ecx);
          chk("repne_term",     {31'd0, repne_term}, {31'd0, e.term});
          chk("busy_cycles",    32'(c_busy),  {24'd0, e.busy_cyc});
          chk("first_of_repne", 32'(c_for),   {24'd0, e.for_cyc});
          chk("ld_ecx_pulses",  32'(c_ldecx), {24'd0, e.ldecx});
          chk("ld_ptrs_pulses", 32'(c_ldp),   {24'd0, e.ldp});
          chk("uop1_cycles",    32'(c_u1),    {24'd0, e.u1});
          chk("uop2_cycles",    32'(c_u2),    {24'd0, e.u2});
        end
      end
    end
  end

  // Driver: issue one instruction and answer uops immediately.
  // zf_bits[i] is the ZF returned by the i-th compare; dual also raises
  // cmp_done while UOP1 is showing, which must be ignored.
  task automatic run_seq(input logic r, input logic [1:0] ds, input logic d,
                         input logic [31:0] esi, input logic [31:0] edi,
                         input logic [31:0] ecx, input logic [7:0] zf_bits,
                         input logic dual, input exp_t e);
    int  iter;
    bit  fin;
    exp_q.push_back(e);
    @(negedge CLK);
    start = 1'b1; rep = r; datasize = ds; df = d;
    esi_in = esi; edi_in = edi; ecx_in = ecx;
    @(negedge CLK);
    start = 1'b0;
    iter  = 0;
    fin   = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      uop_ack  = first_uop;
      cmp_done = second_uop | (dual & first_uop);
      zf_in    = second_uop ? zf_bits[iter[2:0]] : (dual & first_uop);
      if (second_uop) iter++;
      if (done) fin = 1'b1;
      else @(negedge CLK);
    end
    uop_ack = 1'b0; cmp_done = 1'b0; zf_in = 1'b0;
    if (!fin) chk("seq_timeout", 32'd1, 32'd0);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_uops"},  {30'd0, first_uop, second_uop}, 32'd0);
    chk({tag, "_for"},   {31'd0, first_of_repne}, 32'd0);
    chk({tag, "_esi"},   esi_out, 32'd0);
    chk({tag, "_edi"},   edi_out, 32'd0);
    chk({tag, "_ecx"},   ecx_out, 32'd0);
    chk({tag, "_ld"},    {30'd0, ld_ptrs, ld_ecx}, 32'd0);
    chk({tag, "_done"},  {30'd0, done, repne_term}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state_o}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    RST = 1'b1; start = 1'b0; rep = 1'b0; datasize = 2'd0; df = 1'b0;
    esi_in = 32'd0; edi_in = 32'd0; ecx_in = 32'd0;
    uop_ack = 1'b0; cmp_done = 1'b0; zf_in = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Non-rep CMPSB
    run_seq(1'b0, 2'd0, 1'b0, 32'h1000, 32'h2000, 32'd7, 8'h00, 1'b0,
            mk(32'h1001, 32'h2001, 32'd7, 1'b0, 3, 0, 0, 1, 1, 1));
    // REPNE CMPSD, no match over three iterations
    run_seq(1'b1, 2'd2, 1'b0, 32'h1000, 32'h2000, 32'd3, 8'h00, 1'b0,
            mk(32'h100C, 32'h200C, 32'd0, 1'b1, 7, 1, 3, 3, 3, 3));
    // REPNE CMPSW, decrementing, match on second compare
    run_seq(1'b1, 2'd1, 1'b1, 32'h1000, 32'h3000, 32'd5, 8'h02, 1'b0,
            mk(32'h0FFC, 32'h2FFC, 32'd3, 1'b1, 5, 1, 2, 2, 2, 2));
    // REPNE with ECX = 0: bypass straight to DONE
    run_seq(1'b1, 2'd0, 1'b0, 32'h5555, 32'h6666, 32'd0, 8'h00, 1'b0,
            mk(32'h5555, 32'h6666, 32'd0, 1'b1, 1, 0, 0, 0, 0, 0));
    // Dword increment wraps past 2^32
    run_seq(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'd1, 8'h00, 1'b0,
            mk(32'h0000_0002, 32'h0000_0004, 32'd1, 1'b0, 3, 0, 0, 1, 1, 1));
    // Byte decrement wraps below 0; non-rep with ECX = 0 still runs
    run_seq(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'd0, 8'h00, 1'b0,
            mk(32'h0000_000F, 32'hFFFF_FFFF, 32'd0, 1'b0, 3, 0, 0, 1, 1, 1));
    // datasize 3 behaves as dword, decrementing, two iterations
    run_seq(1'b1, 2'd3, 1'b1, 32'h100, 32'h200, 32'd2, 8'h00, 1'b0,
            mk(32'h0F8, 32'h1F8, 32'd0, 1'b1, 5, 1, 2, 2, 2, 2));
    // uop_ack and cmp_done together in UOP1: only uop_ack counts
    run_seq(1'b0, 2'd1, 1'b0, 32'h200, 32'h300, 32'd9, 8'h00, 1'b1,
            mk(32'h202, 32'h302, 32'd9, 1'b0, 3, 0, 0, 1, 1, 1));

    // Ignored inputs, then reset in UOP2
    @(negedge CLK);
    start = 1'b1; rep = 1'b1; datasize = 2'd0; df = 1'b0;
    esi_in = 32'hA000; edi_in = 32'hB000; ecx_in = 32'd4;
    @(negedge CLK);
    chk("ign_in_uop1", {31'd0, first_uop}, 32'd1);
    start = 1'b1; esi_in = 32'hDEAD; edi_in = 32'hBEEF; ecx_in = 32'd99;
    cmp_done = 1'b1; zf_in = 1'b1;
    @(negedge CLK);
    start = 1'b0; cmp_done = 1'b0; zf_in = 1'b0;
    chk("ign_still_uop1", {31'd0, first_uop}, 32'd1);
    chk("ign_for",        {31'd0, first_of_repne}, 32'd1);
    chk("ign_esi",        esi_out, 32'hA000);
    chk("ign_edi",        edi_out, 32'hB000);
    chk("ign_ecx",        ecx_out, 32'd4);
    chk("ign_ld",         {30'd0, ld_ptrs, ld_ecx}, 32'd0);
    uop_ack = 1'b1;
    @(negedge CLK);
    uop_ack = 1'b0;
    chk("rst_in_uop2", {31'd0, second_uop}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_all_zero("midrst");
    repeat (2) begin
      @(negedge CLK);
      chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    end

    // Recovery after reset
    run_seq(1'b1, 2'd0, 1'b0, 32'h40, 32'h80, 32'd2, 8'h01, 1'b0,
            mk(32'h41, 32'h81, 32'd1, 1'b1, 3, 1, 1, 1, 1, 1));

    repeat (3) @(negedge CLK);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
